// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI slave front-end for a small RAM. A transaction is framed by ss_n_i low.
// Each frame is 10 bits, MSB first: [9:8] command, [7:0] address/data.
// Bit 9 selects write (0) or read (1). A read is split into two frames: the
// first carries the read address (READ_ADD), the second is a dummy frame
// (READ_DATA). After the dummy frame the slave waits for the RAM to return a
// byte on tx_data_i/tx_valid_i and shifts it out on miso_o, MSB first.
//
// Ports:
//   clk         system clock; mosi_i sampled and miso_o driven on rising edge
//   rst_n       asynchronous active-low reset
//   ss_n_i      slave select, active low
//   mosi_i      serial data in, MSB first
//   miso_o      serial read data out, MSB first; 0 when not shifting
//   rx_data_o   last completed 10-bit frame
//   rx_valid_o  one-cycle strobe, rx_data_o updated
//   tx_data_i   read data from the RAM
//   tx_valid_i  tx_data_i valid strobe
//
// Configuration:
//   SPI_CMD_CHECK_EN  when defined, a completed frame whose command bits [9:8]
//                     disagree with the receiving state is dropped (no strobe,
//                     rx_data_o and the read-address flag untouched) and the
//                     FSM returns to IDLE. When undefined every completed frame
//                     is strobed.
// -----------------------------------------------------------------------------
module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ss_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic [9:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StChkCmd   = 3'd1,
        StWrite    = 3'd2,
        StReadAdd  = 3'd3,
        StReadData = 3'd4
    } state_e;

    state_e      state_q;
    logic [8:0]  frame_q;        // bits 9..1 of the frame in flight
    logic [3:0]  bit_cnt_q;      // bits shifted in since CHK_CMD
    logic        frame_done_q;   // frame complete, stop shifting until SS_n rises
    logic        rd_addr_seen_q; // a READ_ADD frame was accepted, next read is data
    logic [7:0]  tx_shift_q;     // remaining read bits, next bit in [7]
    logic [2:0]  tx_cnt_q;       // read bits still to present after the current one
    logic        tx_busy_q;      // miso_o is carrying read data
    logic        tx_done_q;      // read byte already sent in this window
    logic        miso_q;
    logic [9:0]  rx_data_q;
    logic        rx_valid_q;

    logic [9:0]  frame_full;
    logic        cmd_ok;

    // Full frame as it would stand after the current edge captures bit 0.
    always_comb begin
        frame_full = {frame_q, mosi_i};
    end

`ifdef SPI_CMD_CHECK_EN
    // frame_q[8:7] are frame bits [9:8] at the moment bit 0 arrives.
    always_comb begin
        cmd_ok = 1'b0;
        case (state_q)
            StWrite:    cmd_ok = ~frame_q[8];
            StReadAdd:  cmd_ok = (frame_q[8:7] == 2'b10);
            StReadData: cmd_ok = (frame_q[8:7] == 2'b11);
            default:    cmd_ok = 1'b0;
        endcase
    end
`else
    always_comb begin
        cmd_ok = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            frame_q        <= '0;
            bit_cnt_q      <= '0;
            frame_done_q   <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_shift_q     <= '0;
            tx_cnt_q       <= '0;
            tx_busy_q      <= 1'b0;
            tx_done_q      <= 1'b0;
            miso_q         <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;

            if (ss_n_i) begin
                // Deselect aborts whatever is in flight; rd_addr_seen_q survives
                // so a split read can span two select windows.
                state_q      <= StIdle;
                frame_q      <= '0;
                bit_cnt_q    <= '0;
                frame_done_q <= 1'b0;
                tx_shift_q   <= '0;
                tx_cnt_q     <= '0;
                tx_busy_q    <= 1'b0;
                tx_done_q    <= 1'b0;
                miso_q       <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        state_q      <= StChkCmd;
                        frame_q      <= '0;
                        bit_cnt_q    <= '0;
                        frame_done_q <= 1'b0;
                        tx_busy_q    <= 1'b0;
                        tx_done_q    <= 1'b0;
                        miso_q       <= 1'b0;
                    end

                    StChkCmd: begin
                        frame_q      <= {8'b0, mosi_i};
                        bit_cnt_q    <= '0;
                        frame_done_q <= 1'b0;
                        if (!mosi_i) begin
                            state_q <= StWrite;
                        end else if (rd_addr_seen_q) begin
                            state_q <= StReadData;
                        end else begin
                            state_q <= StReadAdd;
                        end
                    end

                    StWrite, StReadAdd, StReadData: begin
                        if (!frame_done_q) begin
                            frame_q   <= frame_full[8:0];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            // Count 8 means this edge captures frame bit 0.
                            if (bit_cnt_q == 4'd8) begin
                                frame_done_q <= 1'b1;
                                bit_cnt_q    <= '0;
                                if (cmd_ok) begin
                                    rx_data_q  <= frame_full;
                                    rx_valid_q <= 1'b1;
                                    if (state_q == StReadAdd) begin
                                        rd_addr_seen_q <= 1'b1;
                                    end else if (state_q == StReadData) begin
                                        rd_addr_seen_q <= 1'b0;
                                    end
                                end else begin
                                    state_q <= StIdle;
                                end
                            end
                        end else if (state_q == StReadData) begin
                            if (tx_busy_q) begin
                                // tx_valid_i is deliberately ignored while shifting.
                                if (tx_cnt_q != 3'd0) begin
                                    miso_q     <= tx_shift_q[7];
                                    tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                                    tx_cnt_q   <= tx_cnt_q - 3'd1;
                                end else begin
                                    miso_q    <= 1'b0;
                                    tx_busy_q <= 1'b0;
                                    tx_done_q <= 1'b1;
                                end
                            end else if (!tx_done_q && tx_valid_i) begin
                                // Bit 7 goes out right away; the rest follow.
                                miso_q     <= tx_data_i[7];
                                tx_shift_q <= {tx_data_i[6:0], 1'b0};
                                tx_cnt_q   <= 3'd7;
                                tx_busy_q  <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign miso_o     = miso_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 clk  input  1  system clock; MOSI sampled and MISO driven on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 SS_n  input  1  slave select, active low; frames a transaction.
REQ-004 MOSI  input  1  serial data in, MSB first.
REQ-005 MISO  output  1  serial read data out, MSB first.
REQ-006 rx_data  output  10  parallel frame to the RAM: [9:8] command, [7:0] address/data.
REQ-007 rx_valid  output  1  one-cycle strobe, rx_data valid.
REQ-008 tx_data  input  8  read data from the RAM.
REQ-009 tx_valid  input  1  tx_data valid strobe from the RAM.

Function
REQ-010 FSM states shall be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-011 IDLE -> CHK_CMD on the edge sampling SS_n=0; otherwise IDLE.
REQ-012 In CHK_CMD, the edge sampling SS_n=0 shall capture MOSI as frame bit 9 and branch:
- bit=0 -> WRITE.
- bit=1 and rd_addr_seen=0 -> READ_ADD.
- bit=1 and rd_addr_seen=1 -> READ_DATA.
REQ-013 In WRITE/READ_ADD/READ_DATA, frame bits 8..0 shall be shifted in on 9 successive edges via a 4-bit counter.
REQ-014 On the edge capturing bit 0: rx_data shall be loaded with the full 10-bit frame, and rx_valid shall be high for exactly the following cycle.
REQ-015 rx_data shall hold its value between strobes.
REQ-016 After the READ_ADD frame strobe, rd_addr_seen shall be set.
REQ-017 After the READ_DATA frame strobe, rd_addr_seen shall be cleared.
REQ-018 After its strobe, READ_DATA shall wait with SS_n low for tx_valid=1, then latch tx_data into an 8-bit shift register.
REQ-019 After the latch, MISO shall present bits 7..0, one per cycle, starting the cycle after the latch.
REQ-020 MISO shall be 0 whenever not shifting read data.
REQ-021 WRITE and READ_ADD shall stay in place after their strobe until SS_n rises.
REQ-022 SS_n sampled high in any state shall force IDLE on that edge:
- partial frame discarded, no rx_valid.
- bit counter and MISO shift cleared.
- rd_addr_seen unchanged.
REQ-023 tx_valid shall be ignored outside READ_DATA.
REQ-024 tx_valid arriving during MISO shifting shall be ignored.
REQ-025 Throughput: one 10-bit frame per SS_n low window; minimum window is 11 cycles (CHK_CMD + 10 bits, bit 9 counted in CHK_CMD).

Reset
REQ-026 rst_n low shall asynchronously force the following, independent of clk:
- state=IDLE
- rx_data=0, rx_valid=0, MISO=0
- counters=0, rd_addr_seen=0, shift registers=0

Configuration
REQ-027 Macro SPI_CMD_CHECK_EN.
REQ-028 When defined, a completed frame's bits [9:8] shall be checked against the state: WRITE requires 00 or 01, READ_ADD requires 10, READ_DATA requires 11.
REQ-029 When defined and a mismatch occurs:
- rx_valid suppressed, rx_data unchanged.
- rd_addr_seen unchanged.
- FSM to IDLE.
REQ-030 When undefined, every completed frame shall be strobed unconditionally.

Verification
REQ-031 Reset mid-frame (after 4 bits) -> next cycle rx_valid=0, MISO=0, state IDLE; a following write frame works normally.
REQ-032 SS_n low, MOSI 00_0000_1010 -> rx_data=0x00A, rx_valid one cycle; then 01_1111_0101 -> rx_data=0x1F5, strobe.
REQ-033 Frame 10_0000_1010 then 11_0101_0101 (dummy), model returns tx_valid=1 with tx_data=0xF5 one cycle after the strobe -> MISO 1,1,1,1,0,1,0,1 on the next 8 cycles; rd_addr_seen back to 0.
REQ-034 SS_n raised after 6 bits of a write frame -> no rx_valid, rx_data unchanged; next frame starts in CHK_CMD.
REQ-035 Read frame starting bit 1 sent twice without data phase -> first goes READ_ADD, second goes READ_DATA.
REQ-036 With SPI_CMD_CHECK_EN, frame 1 then [8]=0 while in READ_DATA (11 expected, 10 sent) -> no rx_valid, FSM IDLE; without the macro -> rx_data=0x2xx strobed.
